// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared definitions for the neuron sequencer: FSM state
//               encoding, default counter widths and the activation data
//               width.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int c_chunk_w  = 4;  // default chunk counter width
    localparam int c_neuron_w = 4;  // default neuron counter width
    localparam int c_data_w   = 8;  // PU activation width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_counter
// Description : Up-counter with synchronous clear, count enable and a
//               programmable terminal value. On an enabled cycle at the
//               terminal value it returns to zero, so the owner never sees
//               it wrap past the terminal.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               i_clr      - force count to zero (priority over i_en)
//               i_en       - advance the count
//               i_term     - terminal value
//               o_count    - current count
//               o_tc       - high while o_count equals i_term
// Revision    : 1.0 - initial release
// ============================================================================
module seq_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_term,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign o_tc    = (count_q == i_term);
    assign o_count = count_q;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = o_tc ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : seq_counter
`default_nettype wire

// File: rtl/neuron_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : neuron_sequencer
// Description : Walks a fully-connected layer one 8-element chunk per cycle,
//               driving memory addresses and the PU bias/accumulator select,
//               and captures the PU activation after each neuron's last chunk.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               start                    - job request (sampled in IDLE only)
//               n_chunks, n_neurons      - job dimensions
//               pu_out                   - PU activation for the current chunk
//               x_addr, w_addr, bias_addr- memory addresses
//               isfirst                  - PU selects bias instead of accumulator
//               busy, done               - job status, end-of-job pulse
//               res_valid/res_idx/res_data - one-cycle result strobe
//               perf_cycles              - RUN-cycle count (optional)
// Options     : NEURON_SEQUENCER_PERF_EN adds the perf_cycles output.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_sequencer
    import nn_pkg::*;
#(
    parameter int CHUNK_W  = c_chunk_w,
    parameter int NEURON_W = c_neuron_w
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CHUNK_W-1:0]          n_chunks,
    input  logic [NEURON_W-1:0]         n_neurons,
    input  logic [c_data_w-1:0]         pu_out,
    output logic [CHUNK_W-1:0]          x_addr,
    output logic [CHUNK_W+NEURON_W-1:0] w_addr,
    output logic [NEURON_W-1:0]         bias_addr,
    output logic                        isfirst,
    output logic                        busy,
    output logic                        done,
    output logic                        res_valid,
    output logic [NEURON_W-1:0]         res_idx,
    output logic [c_data_w-1:0]         res_data
`ifdef NEURON_SEQUENCER_PERF_EN
    ,
    output logic [15:0]                 perf_cycles
`endif
);

    state_e                        state_q, state_d;
    logic [CHUNK_W-1:0]            n_chunks_q, n_chunks_d;
    logic [NEURON_W-1:0]           n_neurons_q, n_neurons_d;
    logic [CHUNK_W+NEURON_W-1:0]   w_addr_q, w_addr_d;
    logic                          res_valid_q, res_valid_d;
    logic [NEURON_W-1:0]           res_idx_q, res_idx_d;
    logic [c_data_w-1:0]           res_data_q, res_data_d;

    logic                          w_launch;
    logic                          w_run;
    logic [CHUNK_W-1:0]            w_chunk;
    logic [NEURON_W-1:0]           w_neuron;
    logic                          w_chunk_tc;
    logic                          w_neuron_tc;
    logic                          w_job_last;

    // Both counters return to zero on the final RUN cycle, so addresses
    // rest at zero in DONE/IDLE without extra clearing.
    seq_counter #(.WIDTH(CHUNK_W)) u_chunk_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_launch),
        .i_en    (w_run),
        .i_term  (n_chunks_q - CHUNK_W'(1)),
        .o_count (w_chunk),
        .o_tc    (w_chunk_tc)
    );

    seq_counter #(.WIDTH(NEURON_W)) u_neuron_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_launch),
        .i_en    (w_run & w_chunk_tc),
        .i_term  (n_neurons_q - NEURON_W'(1)),
        .o_count (w_neuron),
        .o_tc    (w_neuron_tc)
    );

    assign w_job_last = w_chunk_tc & w_neuron_tc;

    always_comb begin
        state_d     = state_q;
        n_chunks_d  = n_chunks_q;
        n_neurons_d = n_neurons_q;
        w_addr_d    = w_addr_q;
        res_valid_d = 1'b0;
        res_idx_d   = res_idx_q;
        res_data_d  = res_data_q;
        w_launch    = 1'b0;
        w_run       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_launch    = 1'b1;
                    n_chunks_d  = n_chunks;
                    n_neurons_d = n_neurons;
                    w_addr_d    = '0;
                    // An empty job has nothing to walk: report done directly.
                    state_d     = ((n_chunks == '0) || (n_neurons == '0)) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
                // Running weight address replaces neuron*n_chunks+chunk.
                w_addr_d = w_job_last ? '0 : w_addr_q + (CHUNK_W + NEURON_W)'(1);
                if (w_chunk_tc) begin
                    res_valid_d = 1'b1;
                    res_idx_d   = w_neuron;
                    res_data_d  = pu_out;
                end
                if (w_job_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_chunks_q  <= '0;
            n_neurons_q <= '0;
            w_addr_q    <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_chunks_q  <= n_chunks_d;
            n_neurons_q <= n_neurons_d;
            w_addr_q    <= w_addr_d;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
            res_data_q  <= res_data_d;
        end
    end

    assign x_addr    = w_chunk;
    assign bias_addr = w_neuron;
    assign w_addr    = w_addr_q;
    assign isfirst   = (state_q == ST_RUN) && (w_chunk == '0);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign res_valid = res_valid_q;
    assign res_idx   = res_idx_q;
    assign res_data  = res_data_q;

`ifdef NEURON_SEQUENCER_PERF_EN
    logic [15:0] perf_cycles_q, perf_cycles_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        if (w_launch) begin
            perf_cycles_d = '0;
        end else if (w_run && (perf_cycles_q != 16'hFFFF)) begin
            perf_cycles_d = perf_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
`endif

endmodule : neuron_sequencer
`default_nettype wire

// File: tb/tb_neuron_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_sequencer
// Description : Self-checking bench for neuron_sequencer. A job-level model
//               expands each accepted job into its expected cycle trace and
//               is compared against the DUT every cycle; directed jobs add
//               literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] n_chunks;
    logic [3:0] n_neurons;
    logic [7:0] pu_out;
    logic [3:0] x_addr;
    logic [7:0] w_addr;
    logic [3:0] bias_addr;
    logic       isfirst, busy, done, res_valid;
    logic [3:0] res_idx;
    logic [7:0] res_data;
`ifdef NEURON_SEQUENCER_PERF_EN
    logic [15:0] perf_cycles;
`endif

    always #5 clk = ~clk;

    neuron_sequencer #(.CHUNK_W(4), .NEURON_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_chunks  (n_chunks),
        .n_neurons (n_neurons),
        .pu_out    (pu_out),
        .x_addr    (x_addr),
        .w_addr    (w_addr),
        .bias_addr (bias_addr),
        .isfirst   (isfirst),
        .busy      (busy),
        .done      (done),
        .res_valid (res_valid),
        .res_idx   (res_idx),
        .res_data  (res_data)
`ifdef NEURON_SEQUENCER_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    // External PU stand-in: combinational from the presented addresses.
    logic pu_inc_mode = 1'b0;
    assign pu_out = pu_inc_mode ? (8'h10 + {4'h0, bias_addr}) : ({bias_addr, x_addr} ^ 8'h5A);

    function automatic int pu_fn(int n, int c);
        logic [3:0] nn, cc;
        nn = n[3:0];
        cc = c[3:0];
        if (pu_inc_mode) return int'(8'h10 + {4'h0, nn});
        return int'({nn, cc} ^ 8'h5A);
    endfunction

    int tests = 0;
    int fails = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- job-level reference model ----------------
    typedef struct packed {
        bit busy, done, isfirst, rv, chk_addr, chk_res;
        int x, b, w, ridx, rdata, perf;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur = '0;

    // Expand a C x N job: one entry per RUN cycle k, then the DONE entry.
    function automatic void build_job(int C, int N);
        exp_t e;
        for (int k = 0; k <= C * N; k++) begin
            e = '0;
            e.busy = 1'b1;
            e.perf = k;
            if (k < C * N) begin
                e.isfirst  = ((k % C) == 0);
                e.x        = k % C;
                e.b        = k / C;
                e.w        = k;
                e.chk_addr = 1'b1;
            end else begin
                e.done = 1'b1;
            end
            if (k > 0 && (k % C) == 0) begin
                e.rv    = 1'b1;
                e.ridx  = k / C - 1;
                e.rdata = pu_fn(k / C - 1, C - 1);
            end
            exp_q.push_back(e);
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur = '0;
            cur.chk_addr = 1'b1;
            cur.chk_res  = 1'b1;
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else if (!cur.busy && start) begin
            build_job(int'(n_chunks), int'(n_neurons));
            cur = exp_q.pop_front();
        end else begin
            cur = '0;
        end
    end

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, cur.busy});
        check("done", {31'd0, done}, {31'd0, cur.done});
        check("isfirst", {31'd0, isfirst}, {31'd0, cur.isfirst});
        check("res_valid", {31'd0, res_valid}, {31'd0, cur.rv});
        if (cur.chk_addr) begin
            check("x_addr", {28'd0, x_addr}, cur.x);
            check("w_addr", {24'd0, w_addr}, cur.w);
            check("bias_addr", {28'd0, bias_addr}, cur.b);
        end
        if (cur.chk_res || cur.rv) begin
            check("res_idx", {28'd0, res_idx}, cur.ridx);
            check("res_data", {24'd0, res_data}, cur.rdata);
        end
`ifdef NEURON_SEQUENCER_PERF_EN
        if (cur.busy || cur.chk_res) check("perf_cycles", {16'd0, perf_cycles}, cur.perf);
`endif
    end

    // ---------------- directed stimulus helpers ----------------
    bit isf_q[$];
    int x_q[$], w_q[$], rd_q[$], ri_q[$];
    int busy_cycles, run_cycles;
    bit done_rv, seen_done;

    task automatic launch(int C, int N, bit hold);
        @(posedge clk);
        #2;
        start     = 1'b1;
        n_chunks  = C[3:0];
        n_neurons = N[3:0];
        @(posedge clk);
        #2;
        if (!hold) start = 1'b0;
    endtask

    task automatic observe_job(int budget);
        isf_q.delete(); x_q.delete(); w_q.delete(); rd_q.delete(); ri_q.delete();
        busy_cycles = 0;
        run_cycles  = 0;
        done_rv     = 1'b0;
        seen_done   = 1'b0;
        for (int i = 0; i < budget && !seen_done; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (busy && !done) begin
                run_cycles++;
                isf_q.push_back(isfirst);
                x_q.push_back(int'(x_addr));
                w_q.push_back(int'(w_addr));
            end
            if (res_valid) begin
                rd_q.push_back(int'(res_data));
                ri_q.push_back(int'(res_idx));
            end
            if (done) begin
                seen_done = 1'b1;
                done_rv   = res_valid;
            end
        end
        check("job_done_seen", {31'd0, seen_done}, 32'd1);
    endtask

    task automatic check_3x2(string tag);
        int exp_isf[6] = '{1, 0, 0, 1, 0, 0};
        int exp_x[6]   = '{0, 1, 2, 0, 1, 2};
        check({tag, "_run_cycles"}, run_cycles, 32'd6);
        check({tag, "_busy_cycles"}, busy_cycles, 32'd7);
        check({tag, "_n_results"}, rd_q.size(), 32'd2);
        for (int i = 0; i < 6 && i < run_cycles; i++) begin
            check({tag, "_isfirst_seq"}, {31'd0, isf_q[i]}, exp_isf[i]);
            check({tag, "_x_seq"}, x_q[i], exp_x[i]);
            check({tag, "_w_seq"}, w_q[i], i);
        end
        if (rd_q.size() == 2) begin
            check({tag, "_res_idx0"}, ri_q[0], 32'd0);
            check({tag, "_res_idx1"}, ri_q[1], 32'd1);
            check({tag, "_res_data0"}, rd_q[0], 32'h58);
            check({tag, "_res_data1"}, rd_q[1], 32'h48);
        end
        check({tag, "_done_with_rv"}, {31'd0, done_rv}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b1;   // reset must win over start
        n_chunks  = 4'd3;
        n_neurons = 4'd2;
        repeat (3) @(posedge clk);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_w_addr", {24'd0, w_addr}, 32'd0);
        check("reset_res_data", {24'd0, res_data}, 32'd0);

        // 3 chunks x 2 neurons
        launch(3, 2, 1'b0);
        observe_job(100);
        check_3x2("t1");
        @(negedge clk);
        check("t1_idle_after", {31'd0, busy}, 32'd0);

        // 1 chunk x 4 neurons, PU returns 0x10+neuron
        pu_inc_mode = 1'b1;
        launch(1, 4, 1'b0);
        observe_job(100);
        check("t2_run_cycles", run_cycles, 32'd4);
        for (int i = 0; i < isf_q.size(); i++) check("t2_isfirst", {31'd0, isf_q[i]}, 32'd1);
        check("t2_n_results", rd_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            check("t2_res_data", rd_q[i], 32'h10 + i);
            check("t2_res_idx", ri_q[i], i);
        end
        pu_inc_mode = 1'b0;

        // empty jobs
        launch(0, 3, 1'b0);
        observe_job(5);
        check("t3a_busy_cycles", busy_cycles, 32'd1);
        check("t3a_results", rd_q.size(), 32'd0);
        launch(3, 0, 1'b0);
        observe_job(5);
        check("t3b_busy_cycles", busy_cycles, 32'd1);
        check("t3b_results", rd_q.size(), 32'd0);
        @(negedge clk);
        check("t3_idle_after", {31'd0, busy}, 32'd0);

        // start pulsed mid-run is ignored
        launch(3, 2, 1'b0);
        fork
            observe_job(100);
            begin
                repeat (2) @(posedge clk);
                #2;
                start    = 1'b1;
                n_chunks = 4'd5;
                @(posedge clk);
                #2;
                start = 1'b0;
            end
        join
        check("t4_run_cycles", run_cycles, 32'd6);

        // start held high relaunches after DONE via one IDLE cycle
        launch(2, 1, 1'b1);
        observe_job(100);
        check("t4b_first_run", run_cycles, 32'd2);
        @(negedge clk);
        check("t4b_idle_gap", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("t4b_relaunch_busy", {31'd0, busy}, 32'd1);
        check("t4b_relaunch_isfirst", {31'd0, isfirst}, 32'd1);
        start = 1'b0;
        observe_job(100);

        // reset on RUN cycle 2 of a 3x2 job
        launch(3, 2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_res_valid", {31'd0, res_valid}, 32'd0);
        check("t5_x_addr", {28'd0, x_addr}, 32'd0);
        check("t5_w_addr", {24'd0, w_addr}, 32'd0);
        check("t5_bias_addr", {28'd0, bias_addr}, 32'd0);
        rst = 1'b0;
        launch(3, 2, 1'b0);
        observe_job(100);
        check_3x2("t5_rerun");

`ifdef NEURON_SEQUENCER_PERF_EN
        launch(15, 15, 1'b0);
        observe_job(400);
        check("t6_run_cycles", run_cycles, 32'd225);
        check("t6_perf_at_done", {16'd0, perf_cycles}, 32'd225);
        @(negedge clk);
        check("t6_perf_hold", {16'd0, perf_cycles}, 32'd225);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_neuron_sequencer
`default_nettype wire
